regfile_writeback_arbiter: RTL and testbench

Sits between the execute-stage result sources and the 32-entry integer register file's single write port.
- Merges a single-cycle ALU result stream and a variable-latency LSU/long-op result stream onto one rd/data/write-enable port.
- Buffers long-op results in a small FIFO.
- Keeps a per-register busy scoreboard so decode can stall on RAW/WAW hazards against outstanding long-latency writes.

---
 rtl/regfile_writeback_arbiter.sv | 100 ++++++++++
 tb/tb_regfile_writeback_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_arbiter.sv
// regfile_writeback_arbiter: merges ALU and buffered long-op results onto the register file
// write port and tracks outstanding long-op destinations for decode hazard detection.
module regfile_writeback_arbiter #(
    parameter int DWIDTH     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            issue_valid_i,
    input  logic                            issue_long_i,
    input  logic [4:0]                      issue_rd_i,
    input  logic [4:0]                      rs1_i,
    input  logic [4:0]                      rs2_i,
    output logic                            hazard_o,
    input  logic                            alu_valid_i,
    output logic                            alu_ready_o,
    input  logic [4:0]                      alu_rd_i,
    input  logic [DWIDTH-1:0]               alu_data_i,
    input  logic                            lsu_valid_i,
    output logic                            lsu_ready_o,
    input  logic [4:0]                      lsu_rd_i,
    input  logic [DWIDTH-1:0]               lsu_data_i,
    output logic [4:0]                      rd_o,
    output logic [DWIDTH-1:0]               datawb_o,
    output logic                            regwren_o,
    output logic [31:0]                     busy_o,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]        mem_rd_q   [FIFO_DEPTH];
    logic [DWIDTH-1:0] mem_data_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [31:0]       busy_q, busy_d;
    logic [4:0]        rd_q, rd_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic              wren_q, wren_d;
    logic              full, push, pop, win;
    logic [4:0]        win_rd;
    logic [DWIDTH-1:0] win_data;

    always_comb begin
        full     = count_q == CW'(FIFO_DEPTH);
        push     = lsu_valid_i & !full;
        // a full FIFO takes the port so the long-op path can never deadlock
        pop      = full | (!alu_valid_i & (count_q != '0));
        win      = pop | alu_valid_i;
        win_rd   = pop ? mem_rd_q[rd_ptr_q] : alu_rd_i;
        win_data = pop ? mem_data_q[rd_ptr_q] : alu_data_i;
        hazard_o = issue_valid_i & (busy_q[rs1_i] | busy_q[rs2_i] | busy_q[issue_rd_i]);
        wren_d   = win & (win_rd != 5'd0);
        rd_d     = wren_d ? win_rd : rd_q;
        data_d   = wren_d ? win_data : data_q;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        busy_d   = busy_q;
        if (pop)
            busy_d[win_rd] = 1'b0;
        if (issue_valid_i & issue_long_i & (issue_rd_i != 5'd0) & !hazard_o)
            busy_d[issue_rd_i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            rd_q     <= '0;
            data_q   <= '0;
            wren_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            wren_q   <= wren_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd_q[wr_ptr_q]   <= lsu_rd_i;
            mem_data_q[wr_ptr_q] <= lsu_data_i;
        end
    end

    assign alu_ready_o  = !full;
    assign lsu_ready_o  = !full;
    assign rd_o         = rd_q;
    assign datawb_o     = data_q;
    assign regwren_o    = wren_q;
    assign busy_o       = busy_q;
    assign fifo_count_o = count_q;
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// tb_regfile_writeback_arbiter: directed scenarios plus random traffic checked against a
// queue-based model of the writeback arbiter and busy scoreboard.
module tb_regfile_writeback_arbiter;
    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid_i, issue_long_i, alu_valid_i, lsu_valid_i;
    logic [4:0]  issue_rd_i, rs1_i, rs2_i, alu_rd_i, lsu_rd_i;
    logic [31:0] alu_data_i, lsu_data_i;
    logic        hazard_o, alu_ready_o, lsu_ready_o, regwren_o;
    logic [4:0]  rd_o;
    logic [31:0] datawb_o, busy_o;
    logic [2:0]  fifo_count_o;

    regfile_writeback_arbiter #(.DWIDTH(32), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst),
        .issue_valid_i(issue_valid_i), .issue_long_i(issue_long_i), .issue_rd_i(issue_rd_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .hazard_o(hazard_o),
        .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
        .rd_o(rd_o), .datawb_o(datawb_o), .regwren_o(regwren_o),
        .busy_o(busy_o), .fifo_count_o(fifo_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_busy = '0;
    logic        m_wren = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_data = '0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic step(input logic iv, input logic il, input logic [4:0] ird,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic av, input logic [4:0] ard, input logic [31:0] adat,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                        input logic r);
        bit          full, haz, win;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        ent_t        e;
        @(negedge clk);
        rst = r; issue_valid_i = iv; issue_long_i = il; issue_rd_i = ird; rs1_i = r1; rs2_i = r2;
        alu_valid_i = av; alu_rd_i = ard; alu_data_i = adat;
        lsu_valid_i = lv; lsu_rd_i = lrd; lsu_data_i = ldat;
        #1;
        full = q.size() == FD;
        haz  = iv && (m_busy[r1] || m_busy[r2] || m_busy[ird]);
        check("alu_ready", 64'(alu_ready_o), 64'(!full));
        check("lsu_ready", 64'(lsu_ready_o), 64'(!full));
        check("fifo_count", 64'(fifo_count_o), 64'(q.size()));
        check("busy", 64'(busy_o), 64'(m_busy));
        check("hazard", 64'(hazard_o), 64'(haz));
        check("regwren", 64'(regwren_o), 64'(m_wren));
        if (m_wren) begin
            check("rd", 64'(rd_o), 64'(m_rd));
            check("data", 64'(datawb_o), 64'(m_data));
        end
        if (r) begin
            q.delete();
            m_busy = '0;
            m_wren = 1'b0;
            m_rd   = '0;
            m_data = '0;
        end else begin
            win = 0; wrd = '0; wdat = '0;
            if (full || (!av && q.size() > 0)) begin
                e = q.pop_front();
                win = 1; wrd = e.rd; wdat = e.data;
                if (wrd != 0) m_busy[wrd] = 1'b0;
            end else if (av) begin
                win = 1; wrd = ard; wdat = adat;
            end
            if (lv && !full) q.push_back('{lrd, ldat});
            if (iv && il && ird != 0 && !haz) m_busy[ird] = 1'b1;
            m_wren = win && wrd != 0;
            if (m_wren) begin
                m_rd = wrd;
                m_data = wdat;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    logic        lv = 0, av = 0;
    logic [4:0]  lrd = 0, ard = 0;
    logic [31:0] ldat = 0, adat = 0;

    initial begin
        rst = 1'b1;
        {issue_valid_i, issue_long_i, alu_valid_i, lsu_valid_i} = '0;
        {issue_rd_i, rs1_i, rs2_i, alu_rd_i, lsu_rd_i} = '0;
        alu_data_i = '0; lsu_data_i = '0;
        repeat (2) @(posedge clk);
        // ALU write of x5
        idle(1);
        step(0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        idle(2);
        // long op to x7, RAW stall, then LSU return
        step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 7, 0, 0, 0, 0, 1, 7, 32'h1234, 0);
        step(1, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        // ALU saturating the port while the FIFO fills
        for (int i = 0; i < 8; i++)
            step(0, 0, 0, 0, 0, 1, 5'(10 + i), 32'(100 + i), i < 4, 5'(20 + i), 32'(200 + i), 0);
        idle(6);
        // concurrent enqueue/dequeue and x9 reissue while its old result drains
        step(1, 1, 9, 0, 0, 0, 0, 0, 1, 9, 32'h99, 0);
        step(0, 0, 0, 0, 0, 1, 3, 32'h33, 1, 4, 32'h44, 0);
        step(1, 1, 9, 0, 0, 0, 0, 0, 1, 6, 32'h66, 0);
        idle(4);
        // x0 writes via both paths and a long issue to x0
        step(1, 1, 0, 0, 0, 1, 0, 32'hAAAA, 1, 0, 32'hBBBB, 0);
        idle(3);
        // reset with buffered entries and busy bits outstanding
        step(1, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 13, 0, 0, 1, 1, 1, 1, 12, 32'hC, 0);
        step(0, 0, 0, 0, 0, 1, 2, 2, 1, 13, 32'hD, 0);
        step(0, 0, 0, 0, 0, 1, 3, 3, 1, 14, 32'hE, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(4);
        for (int i = 0; i < 800; i++) begin
            if (!(lv && q.size() == FD)) begin
                lv = $urandom_range(0, 1); lrd = 5'($urandom_range(0, 7)); ldat = $urandom;
            end
            if (!(av && q.size() == FD)) begin
                av = ($urandom_range(0, 2) == 0); ard = 5'($urandom_range(0, 7)); adat = $urandom;
            end
            step($urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 av, ard, adat, lv, lrd, ldat, $urandom_range(0, 99) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
